mac_arb2: RTL and testbench
===========================

MAC_ARB2 -- requirements
Module: mac_arb2

Interface
REQ-001 SHALL have parameter ACC_W, default 20, giving the accumulator and result width in bits (legal range 17..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports inN_valid  input  1  requester N (N=0,1) operand valid.
REQ-005 SHALL have ports inN_ready  output  1  requester N operand accepted this cycle.
REQ-006 SHALL have ports inN_a, inN_b  input  8 each  signed two's-complement operands.
REQ-007 SHALL have ports inN_last  input  1  final term of requester N's dot product.
REQ-008 SHALL have port out_valid  output  1  result register holds a result.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_id  output  1  requester that owns the result.
REQ-011 SHALL have port out_acc  output  ACC_W  signed accumulated result.
REQ-012 SHALL have port out_sat  output  1  saturation occurred during this dot product.

Function
REQ-013 SHALL instantiate exactly one mult8x8 (radix-4 Booth, signed 8x8 -> 16) and share it between both requesters.
REQ-014 SHALL compute stall = stage_v & stage_last & out_valid & ~out_ready.
REQ-015 SHALL drive in0_ready = ~stall & (prio==0 | ~in1_valid) and in1_ready = ~stall & (prio==1 | ~in0_valid); inN_ready never depends on inN_valid.
REQ-016 SHALL transfer on inN_valid & inN_ready; at most one transfer per cycle.
REQ-017 SHALL, on transfer, load stage register {a, b, id, last} and set stage_v; with no transfer and no stall, clear stage_v.
REQ-018 SHALL flip prio to the other requester after each transfer; prio unchanged otherwise.
REQ-019 SHALL, when stage_v & ~stall, sign-extend the 16-bit product to ACC_W and add it to acc[id] at the same edge the next operand may load (one op per cycle throughput).
REQ-020 SHALL, when the stage op has last=1, load out_acc/out_id/out_sat with the sum, set out_valid, and clear acc[id] and sat[id] to 0 at that edge.
REQ-021 SHALL give a latency of 2 edges: last-term transfer at edge k -> out_valid high after edge k+1 (when not stalled).
REQ-022 SHALL allow the result register to load when ~out_valid | out_ready (same-cycle replace); if only out_ready, out_valid clears.
REQ-023 SHALL hold the stage register, accumulators, prio and result unchanged while stall=1.
REQ-024 SHALL keep acc[0] and acc[1] fully independent; interleaved transfers never mix.
REQ-025 SHALL without saturation wrap modulo 2^ACC_W and hold out_sat at 0.

Reset
REQ-026 SHALL on rst_n low asynchronously clear stage_v, out_valid, out_id, out_acc, out_sat, acc[0], acc[1], sat[0], sat[1], and set prio=0; in-flight terms are discarded.
REQ-027 SHALL drive inN_ready per REQ-015 during and after reset (stall=0 since stage_v=0).

Configuration
REQ-028 SHALL, when macro MAC_ARB_SAT_EN is defined, clamp every addition to [-2^(ACC_W-1), 2^(ACC_W-1)-1], set sticky sat[id] on any clamp and report it on out_sat with the result.
REQ-029 SHALL, when MAC_ARB_SAT_EN is undefined, omit clamp logic, wrap per REQ-025, and tie out_sat to 0.

Verification
REQ-030 SHALL cover single term: in0 a=-3,b=7,last=1 -> next-but-one cycle out_valid=1, out_id=0, out_acc=-21.
REQ-031 SHALL cover round-robin: both valid continuously for 4 cycles -> grants 0,1,0,1; in1 terms (2*3,last on 2nd) gives 12, in0 terms (-128*-128 twice) gives 32768.
REQ-032 SHALL cover backpressure: out_ready=0 with result pending and second last term in stage -> both inN_ready=0, no state change; out_ready=1 one cycle -> second result loads next edge.
REQ-033 SHALL cover saturation (ACC_W=20): 32 terms of -128*-128 -> with MAC_ARB_SAT_EN out_acc=524287, out_sat=1; without, out_acc=-524288, out_sat=0.
REQ-034 SHALL cover reset mid-product: 3 non-last terms on in0, rst_n low 1 cycle, then a=1,b=1,last=1 -> out_acc=1, prio=0.
REQ-035 SHALL cover 1000 random interleaved operands against a behavioural signed-MAC model, zero mismatches.

Source files
------------

// File: rtl/mac_arb2_if.sv
// mac_arb2_if: requester-side operand handshakes and consumer-side result
// handshake of the two-requester shared multiply-accumulate unit.
interface mac_arb2_if #(
  parameter int unsigned ACC_W = 20
);

  // Requester 0 operand channel
  logic             in0_valid;
  logic             in0_ready;
  logic [7:0]       in0_a;
  logic [7:0]       in0_b;
  logic             in0_last;

  // Requester 1 operand channel
  logic             in1_valid;
  logic             in1_ready;
  logic [7:0]       in1_a;
  logic [7:0]       in1_b;
  logic             in1_last;

  // Result channel
  logic             out_valid;
  logic             out_ready;
  logic             out_id;
  logic [ACC_W-1:0] out_acc;
  logic             out_sat;

  // Requesters and consumer side
  modport master (
    output in0_valid, in0_a, in0_b, in0_last,
    output in1_valid, in1_a, in1_b, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_id, out_acc, out_sat
  );

  // MAC unit side
  modport slave (
    input  in0_valid, in0_a, in0_b, in0_last,
    input  in1_valid, in1_a, in1_b, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_id, out_acc, out_sat
  );

endinterface

// File: rtl/mac_arb2.sv
// mac_arb2: two requesters share one signed 8x8 Booth multiplier through a
// round-robin arbiter; each requester owns an ACC_W-bit accumulator and gets
// its dot product on a single registered result channel.
// Optional feature: define MAC_ARB_SAT_EN to clamp every accumulation to the
// signed ACC_W range and report a sticky saturation flag with the result.
// Without it the accumulators wrap and out_sat is tied low.

// Radix-4 Booth signed 8x8 -> 16 multiplier (purely combinational).
module mult8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  localparam int unsigned PROD_W = 16;

  logic [8:0]        b_ext;
  logic [PROD_W-1:0] a_ext;

  // One Booth partial product from a 3-bit multiplier window
  function automatic logic [PROD_W-1:0] booth_pp(input logic [2:0] grp,
                                                 input logic [PROD_W-1:0] m);
    logic [PROD_W-1:0] r;
    case (grp)
      3'b001, 3'b010: r = m;
      3'b011:         r = m << 1;
      3'b100:         r = -(m << 1);
      3'b101, 3'b110: r = -m;
      default:        r = '0;
    endcase
    return r;
  endfunction

  assign b_ext = {b, 1'b0};
  assign a_ext = {{8{a[7]}}, a};

  // Sum of the four shifted partial products, modulo 2^16
  always_comb begin
    p = booth_pp(b_ext[2:0], a_ext)
      + (booth_pp(b_ext[4:2], a_ext) << 2)
      + (booth_pp(b_ext[6:4], a_ext) << 4)
      + (booth_pp(b_ext[8:6], a_ext) << 6);
  end

endmodule

module mac_arb2 #(
  parameter int unsigned ACC_W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  mac_arb2_if.slave    bus
);

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned EXT_W  = ACC_W - PROD_W;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            id;
    logic            last;
  } stage_t;

  // Operand stage
  stage_t            stage_q;
  stage_t            stage_d_c;
  logic              stage_v;
  logic              prio;

  // Per-requester accumulators
  logic [ACC_W-1:0]  acc_q [2];

  // Result register
  logic              out_valid_q;
  logic              out_id_q;
  logic [ACC_W-1:0]  out_acc_q;

  // Arbitration and datapath combinational signals
  logic              stall_c;
  logic              in0_ready_c;
  logic              in1_ready_c;
  logic              xfer0_c;
  logic              xfer1_c;
  logic              xfer_c;
  logic              step_c;
  logic [PROD_W-1:0] prod_c;
  logic [ACC_W-1:0]  prod_ext_c;
  logic [ACC_W-1:0]  acc_sel_c;
  logic [ACC_W-1:0]  sum_c;

  // Hold everything while a finished sum waits behind an unaccepted result
  always_comb begin
    stall_c     = stage_v & stage_q.last & out_valid_q & ~bus.out_ready;
    in0_ready_c = ~stall_c & (~prio | ~bus.in1_valid);
    in1_ready_c = ~stall_c & ( prio | ~bus.in0_valid);
    xfer0_c     = bus.in0_valid & in0_ready_c;
    xfer1_c     = bus.in1_valid & in1_ready_c;
    xfer_c      = xfer0_c | xfer1_c;
    step_c      = stage_v & ~stall_c;
  end

  // Stage payload from the granted requester
  always_comb begin
    stage_d_c = '{a: bus.in1_a, b: bus.in1_b, id: 1'b1, last: bus.in1_last};
    if (xfer0_c) begin
      stage_d_c = '{a: bus.in0_a, b: bus.in0_b, id: 1'b0, last: bus.in0_last};
    end
  end

  mult8x8 u_mult (
    .a (stage_q.a),
    .b (stage_q.b),
    .p (prod_c)
  );

  // Sign-extended product and the owning accumulator
  always_comb begin
    prod_ext_c = {{EXT_W{prod_c[PROD_W-1]}}, prod_c};
    acc_sel_c  = acc_q[stage_q.id];
  end

`ifdef MAC_ARB_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]       sat_q;
  logic [ACC_W:0]   wide_c;
  logic             ovf_c;
  logic             sat_sum_c;
  logic             out_sat_q;

  // One guard bit detects overflow; clamp toward the sign of the true sum
  always_comb begin
    wide_c    = {acc_sel_c[ACC_W-1], acc_sel_c} + {prod_ext_c[ACC_W-1], prod_ext_c};
    ovf_c     = wide_c[ACC_W] ^ wide_c[ACC_W-1];
    sum_c     = wide_c[ACC_W-1:0];
    if (ovf_c) begin
      sum_c = wide_c[ACC_W] ? ACC_MIN : ACC_MAX;
    end
    sat_sum_c = sat_q[stage_q.id] | ovf_c;
  end

  // Sticky saturation flags, cleared when their dot product completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (step_c) begin
      sat_q[stage_q.id] <= stage_q.last ? 1'b0 : sat_sum_c;
    end
  end

  // Saturation flag travels with the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat_q <= 1'b0;
    end else if (step_c && stage_q.last) begin
      out_sat_q <= sat_sum_c;
    end
  end

  assign bus.out_sat = out_sat_q;
`else
  // Plain modulo-2^ACC_W accumulation
  always_comb begin
    sum_c = acc_sel_c + prod_ext_c;
  end

  assign bus.out_sat = 1'b0;
`endif

  // Operand stage and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      stage_v <= 1'b0;
      prio    <= 1'b0;
    end else if (xfer_c) begin
      stage_q <= stage_d_c;
      stage_v <= 1'b1;
      prio    <= ~prio;
    end else if (!stall_c) begin
      stage_v <= 1'b0;
    end
  end

  // Accumulate the staged term; a final term empties its accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q[0] <= '0;
      acc_q[1] <= '0;
    end else if (step_c) begin
      acc_q[stage_q.id] <= stage_q.last ? '0 : sum_c;
    end
  end

  // Result register: load on a final term, otherwise drain on out_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_acc_q   <= '0;
    end else if (step_c && stage_q.last) begin
      out_valid_q <= 1'b1;
      out_id_q    <= stage_q.id;
      out_acc_q   <= sum_c;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in0_ready = in0_ready_c;
  assign bus.in1_ready = in1_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_acc   = out_acc_q;

endmodule

// File: tb/tb_mac_arb2.sv
// tb_mac_arb2: table of single-term products, hand-written multi-cycle
// sequences and random interleaving, all checked against a scoreboard fed by
// a behavioural signed MAC model.
module tb_mac_arb2;

  localparam int unsigned ACC_W = 20;
  localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) << (ACC_W - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mac_arb2_if #(.ACC_W(ACC_W)) bus ();

  mac_arb2 #(.ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic   id;
    longint acc;
    logic   sat;
  } res_t;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [7:0] b;
    longint     exp_acc;
  } vec_t;

  int     total = 0;
  int     bad = 0;
  res_t   exp_q[$];
  longint m_sum[2] = '{0, 0};
  logic   m_sat[2] = '{1'b0, 1'b0};
  logic   m_prio = 1'b0;
  int     xfer_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'($signed(t));
  endfunction

  // Observe handshakes just before the next rising edge
  task automatic monitor();
    logic       t0, t1, id, last, ovf;
    logic [7:0] a, b;
    longint     s;
    res_t       r;
    if (!rst_n) begin
      m_sum = '{0, 0};
      m_sat = '{1'b0, 1'b0};
      m_prio = 1'b0;
      exp_q.delete();
      return;
    end
    t0 = bus.in0_valid & bus.in0_ready;
    t1 = bus.in1_valid & bus.in1_ready;
    if (bus.in0_valid && bus.in1_valid && (t0 || t1)) begin
      chk("one_xfer", longint'(t0 & t1), 0);
      chk("rr_grant", longint'(t1), longint'(m_prio));
    end
    if (t0 || t1) begin
      id   = t1;
      a    = t1 ? bus.in1_a : bus.in0_a;
      b    = t1 ? bus.in1_b : bus.in0_b;
      last = t1 ? bus.in1_last : bus.in0_last;
      s    = m_sum[id] + longint'($signed(a)) * longint'($signed(b));
      ovf  = 1'b0;
`ifdef MAC_ARB_SAT_EN
      if (s > ACC_MAX) begin
        s = ACC_MAX;
        ovf = 1'b1;
      end else if (s < ACC_MIN) begin
        s = ACC_MIN;
        ovf = 1'b1;
      end
`else
      s = wrap(s);
`endif
      if (last) begin
        r.id  = id;
        r.acc = s;
        r.sat = m_sat[id] | ovf;
        exp_q.push_back(r);
        m_sum[id] = 0;
        m_sat[id] = 1'b0;
      end else begin
        m_sum[id] = s;
        m_sat[id] = m_sat[id] | ovf;
      end
      m_prio = ~m_prio;
      xfer_cnt++;
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("sb_pending", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        chk("sb_id", longint'(bus.out_id), longint'(r.id));
        chk("sb_acc", longint'($signed(bus.out_acc)), r.acc);
        chk("sb_sat", longint'(bus.out_sat), longint'(r.sat));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    bus.in0_valid = v;
    bus.in0_a     = a;
    bus.in0_b     = b;
    bus.in0_last  = l;
  endtask

  task automatic drive1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    bus.in1_valid = v;
    bus.in1_a     = a;
    bus.in1_b     = b;
    bus.in1_last  = l;
  endtask

  initial begin
    vec_t vecs[6];
    logic exp_g[4];
    int   i0, i1, n, cyc;

    vecs[0] = '{1'b0, 8'hFD, 8'h07, -21};
    vecs[1] = '{1'b1, 8'h05, 8'h06, 30};
    vecs[2] = '{1'b0, 8'h80, 8'h80, 16384};
    vecs[3] = '{1'b1, 8'h7F, 8'h80, -16256};
    vecs[4] = '{1'b0, 8'h00, 8'h63, 0};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 1};
    exp_g   = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_out_id", longint'(bus.out_id), 0);
    chk("rst_out_acc", longint'($signed(bus.out_acc)), 0);
    chk("rst_out_sat", longint'(bus.out_sat), 0);
    chk("rst_rdy0_idle", longint'(bus.in0_ready), 1);
    chk("rst_rdy1_idle", longint'(bus.in1_ready), 1);
    drive0(1'b1, 8'h00, 8'h00, 1'b0);
    drive1(1'b1, 8'h00, 8'h00, 1'b0);
    #1;
    chk("rst_rdy0_both", longint'(bus.in0_ready), 1);
    chk("rst_rdy1_both", longint'(bus.in1_ready), 0);
    tick();
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single-term products, one per requester in turn
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].id) drive1(1'b1, vecs[v].a, vecs[v].b, 1'b1);
      else            drive0(1'b1, vecs[v].a, vecs[v].b, 1'b1);
      tick();
      chk("lat_early", longint'(bus.out_valid), 0);
      drive0(1'b0, 8'h00, 8'h00, 1'b0);
      drive1(1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk("vec_valid", longint'(bus.out_valid), 1);
      chk("vec_id", longint'(bus.out_id), longint'(vecs[v].id));
      chk("vec_acc", longint'($signed(bus.out_acc)), vecs[v].exp_acc);
    end

    // Round robin with both requesters continuously valid
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 4; c++) begin
      drive0(1'b1, 8'h80, 8'h80, i0 == 1);
      drive1(1'b1, 8'h02, 8'h03, i1 == 1);
      #1;
      chk("rr_rdy0", longint'(bus.in0_ready), longint'(!exp_g[c]));
      chk("rr_rdy1", longint'(bus.in1_ready), longint'(exp_g[c]));
      tick();
      if (exp_g[c]) i1++;
      else          i0++;
    end
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    chk("rr_res0_id", longint'(bus.out_id), 0);
    chk("rr_res0_acc", longint'($signed(bus.out_acc)), 32768);
    tick();
    chk("rr_res1_id", longint'(bus.out_id), 1);
    chk("rr_res1_acc", longint'($signed(bus.out_acc)), 12);
    tick();

    // Backpressure: pending result plus a final term in the stage
    bus.out_ready = 1'b0;
    drive0(1'b1, 8'h02, 8'h02, 1'b1);
    tick();
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b1, 8'h03, 8'h03, 1'b1);
    tick();
    drive0(1'b1, 8'h05, 8'h05, 1'b1);
    drive1(1'b1, 8'h06, 8'h06, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_rdy0", longint'(bus.in0_ready), 0);
      chk("bp_rdy1", longint'(bus.in1_ready), 0);
      chk("bp_valid", longint'(bus.out_valid), 1);
      chk("bp_id", longint'(bus.out_id), 0);
      chk("bp_acc", longint'($signed(bus.out_acc)), 4);
      tick();
    end
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("bp_next_valid", longint'(bus.out_valid), 1);
    chk("bp_next_id", longint'(bus.out_id), 1);
    chk("bp_next_acc", longint'($signed(bus.out_acc)), 9);
    bus.out_ready = 1'b1;
    tick();
    tick();

    // Saturation boundary: 32 x (-128 * -128) = 2^19
    for (int k = 0; k < 32; k++) begin
      drive0(1'b1, 8'h80, 8'h80, k == 31);
      tick();
    end
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("sat_valid", longint'(bus.out_valid), 1);
`ifdef MAC_ARB_SAT_EN
    chk("sat_acc", longint'($signed(bus.out_acc)), 524287);
    chk("sat_flag", longint'(bus.out_sat), 1);
`else
    chk("sat_acc", longint'($signed(bus.out_acc)), -524288);
    chk("sat_flag", longint'(bus.out_sat), 0);
`endif
    tick();

    // Reset in the middle of a dot product
    for (int k = 0; k < 3; k++) begin
      drive0(1'b1, 8'h05, 8'h05, 1'b0);
      tick();
    end
    rst_n = 1'b0;
    drive1(1'b1, 8'h07, 8'h07, 1'b1);
    #1;
    chk("mr_rdy0", longint'(bus.in0_ready), 1);
    chk("mr_rdy1", longint'(bus.in1_ready), 0);
    chk("mr_valid", longint'(bus.out_valid), 0);
    tick();
    rst_n = 1'b1;
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    drive0(1'b1, 8'h01, 8'h01, 1'b1);
    tick();
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("mr_res_valid", longint'(bus.out_valid), 1);
    chk("mr_res_id", longint'(bus.out_id), 0);
    chk("mr_res_acc", longint'($signed(bus.out_acc)), 1);
    tick();

    // Random interleaving against the scoreboard
    xfer_cnt = 0;
    cyc = 0;
    while (xfer_cnt < 1000 && cyc < 20000) begin
      drive0(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0);
      drive1(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             $urandom_range(0, 3) == 0);
      bus.out_ready = $urandom_range(0, 9) < 7;
      tick();
      cyc++;
    end
    chk("rand_count", longint'(xfer_cnt >= 1000), 1);
    drive0(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 8'h00, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk("drain", longint'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
